// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter granting bounded bursts into a shared fifo
// Ports:
//   clock, reset      sole clock, synchronous active-high reset
//   req, req_data     per-producer request and word (slice i = [i*DATA_WIDTH +: DATA_WIDTH])
//   fifo_full         fifo backpressure; blocks every grant
//   gnt               one-hot (or zero) combinational grant
//   write_en, data_in fifo write side
//   owner, busy       registered burst owner and OWN-state flag
//   stall_count       saturating count of cycles with a request blocked by fifo_full
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          write_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          stall_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;
  logic [0:0]    state;
  logic [IW-1:0] rr_ptr, start, win, sel, idx;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          keep, found, grant;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction
  assign keep      = (state == OWN) && req[owner];
  assign start     = (state == OWN) ? nxt(owner) : rr_ptr;
  assign sel       = keep ? owner : win;
  assign grant     = !reset && !fifo_full && (keep || found);
  assign burst_nxt = burst_cnt + 1'b1;
  assign busy      = (state == OWN);
  assign write_en  = grant;
  assign gnt       = grant ? NUM_REQ'(1) << sel : '0;
  assign data_in   = grant ? req_data[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
  // descending scan so the closest requester to start is written last and wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(start) + k) % NUM_REQ);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      burst_cnt   <= '0;
      rr_ptr      <= '0;
      stall_count <= '0;
    end else begin
      if (|req && fifo_full && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (keep) begin
        if (grant && burst_nxt == BW'(MAX_BURST)) begin
          state     <= IDLE;
          rr_ptr    <= nxt(owner);
          owner     <= '0;
          burst_cnt <= '0;
        end else if (grant) begin
          burst_cnt <= burst_nxt;
        end
      end else if (grant && MAX_BURST == 1) begin
        rr_ptr <= nxt(win);
      end else if (grant) begin
        state     <= OWN;
        owner     <= win;
        burst_cnt <= BW'(1);
      end else if (state == OWN) begin
        // owner released with nobody eligible: rotate past it
        state     <= IDLE;
        rr_ptr    <= nxt(owner);
        owner     <= '0;
        burst_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks of fifo_wr_arbiter against a burst/round-robin model
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          reset = 1'b1, fifo_full = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  gnt, gnt2;
  logic          write_en, we2, busy, busy2;
  logic [DW-1:0] data_in, di2;
  logic [1:0]    owner, owner2;
  logic [15:0]   stall;
  logic [3:0]    stall2;
  int total = 0, bad = 0, started = 0;
  logic [7:0] pd [N];
  int m_busy = 0, m_owner = 0, m_cnt = 0, m_ptr = 0, m_stall = 0, m_stall4 = 0;
  int exp_g;
  logic [7:0] dut_q [$];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(16)) dut (
    .clock(clk), .reset(reset), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .gnt(gnt), .write_en(write_en), .data_in(data_in), .owner(owner), .busy(busy), .stall_count(stall));
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(4)) dut4 (
    .clock(clk), .reset(reset), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .gnt(gnt2), .write_en(we2), .data_in(di2), .owner(owner2), .busy(busy2), .stall_count(stall2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one cycle: check registered outputs, drive inputs, check combinational outputs, advance model
  task automatic step(input logic [N-1:0] r, input logic f, input logic rs);
    int s;
    @(negedge clk);
    if (started != 0) begin
      chk("owner", 32'(owner), 32'(m_owner));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("stall", 32'(stall), 32'(m_stall));
      chk("stall4", 32'(stall2), 32'(m_stall4));
    end
    started = 1;
    reset = rs; req = r; fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pd[i];
    #1;
    exp_g = -1;
    if (rs) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_stall = 0; m_stall4 = 0;
    end else begin
      if (|r && f) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (m_busy == 1 && r[2'(m_owner)]) begin
        if (!f) begin
          exp_g = m_owner;
          m_cnt++;
          if (m_cnt == MB) begin
            m_busy = 0; m_ptr = (m_owner + 1) % N; m_owner = 0; m_cnt = 0;
          end
        end
      end else begin
        s = (m_busy == 1) ? (m_owner + 1) % N : m_ptr;
        if (!f) for (int k = 0; k < N; k++) if (exp_g < 0 && r[2'((s + k) % N)]) exp_g = (s + k) % N;
        if (exp_g >= 0) begin
          m_busy = 1; m_owner = exp_g; m_cnt = 1;
        end else if (m_busy == 1) begin
          m_busy = 0; m_ptr = (m_owner + 1) % N; m_owner = 0; m_cnt = 0;
        end
      end
    end
    chk("gnt", 32'(gnt), exp_g >= 0 ? 32'(1) << exp_g : 32'd0);
    chk("gnt4", 32'(gnt2), exp_g >= 0 ? 32'(1) << exp_g : 32'd0);
    chk("write_en", 32'(write_en), exp_g >= 0 ? 32'd1 : 32'd0);
    chk("data_in", 32'(data_in), exp_g >= 0 ? 32'(pd[exp_g]) : 32'd0);
    if (write_en) dut_q.push_back(data_in);
    if (exp_g >= 0) pd[exp_g] = pd[exp_g] + 8'd1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) pd[i] = 8'(8'h40 * i);
    step('0, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_we", 32'(write_en), 32'd0);
    // single producer streams continuously across burst boundaries
    pd[2] = 8'h10;
    dut_q.delete();
    repeat (6) begin
      step(4'b0100, 1'b0, 1'b0);
      chk("t1_gnt", 32'(gnt), 32'h4);
    end
    chk("t1_count", 32'(dut_q.size()), 32'd6);
    for (int k = 0; k < 6 && k < dut_q.size(); k++) chk("t1_word", 32'(dut_q[k]), 32'(8'h10 + k));
    // all requesting: four-word bursts in rotation
    step('0, 1'b0, 1'b1);
    dut_q.delete();
    for (int k = 0; k < 16; k++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("t2_gnt", 32'(gnt), 32'(1) << (k / 4));
    end
    chk("t2_writes", 32'(dut_q.size()), 32'd16);
    // backpressure mid-burst keeps ownership
    step('0, 1'b0, 1'b1);
    repeat (2) step(4'b0010, 1'b0, 1'b0);
    repeat (3) begin
      step(4'b0010, 1'b1, 1'b0);
      chk("t3_gnt_full", 32'(gnt), 32'd0);
      chk("t3_we_full", 32'(write_en), 32'd0);
    end
    step(4'b0010, 1'b0, 1'b0);
    chk("t3_stall", 32'(stall), 32'd3);
    chk("t3_gnt_a", 32'(gnt), 32'h2);
    step(4'b0010, 1'b0, 1'b0);
    chk("t3_gnt_b", 32'(gnt), 32'h2);
    step(4'b1111, 1'b0, 1'b0);
    chk("t3_rr", 32'(gnt), 32'h4);
    // early release by owner 3 wraps to producer 0
    step('0, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    chk("t4_first", 32'(gnt), 32'h8);
    step(4'b0011, 1'b0, 1'b0);
    chk("t4_next", 32'(gnt), 32'h1);
    // reset mid-burst
    step('0, 1'b0, 1'b1);
    repeat (2) step(4'b0100, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    chk("t5_gnt_rst", 32'(gnt), 32'd0);
    chk("t5_we_rst", 32'(write_en), 32'd0);
    step(4'b1111, 1'b0, 1'b0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_owner", 32'(owner), 32'd0);
    chk("t5_stall", 32'(stall), 32'd0);
    chk("t5_gnt", 32'(gnt), 32'h1);
    // saturation of the narrow counter
    step('0, 1'b0, 1'b1);
    repeat (20) step(4'b0001, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("t6_sat4", 32'(stall2), 32'd15);
    chk("t6_stall16", 32'(stall), 32'd20);
    // random traffic against the model
    for (int k = 0; k < 400; k++)
      step(4'($urandom), ($urandom % 4) == 0, ($urandom % 60) == 0);
    step('0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
